dmem_dma_master: RTL
====================

// Module: dmem_dma_master
// PURPOSE
//  Bus initiator for the HACK data-memory bus (we/addr/data_in/data_out). Runs COPY or FILL transfers into
//  RAM and memory-mapped registers while the CPU is held off via a req/gnt handshake.
//  Sits beside the CPU; a bus mux in the top level selects this block's outputs while bus_gnt=1.
// PARAMETERS
//  AW      15   address width, matches the data-memory address bus
//  DW      16   data width
//  LENW    15   transfer-length counter width
// PORTS
//  clk50m      in   1     system clock, 50 MHz
//  rst_n       in   1     asynchronous reset, active low
//  start       in   1     1-cycle pulse; latches cfg_* and begins a transfer (ignored while busy)
//  cfg_mode    in   1     0=COPY, 1=FILL
//  cfg_src     in   AW    COPY source start address
//  cfg_dst     in   AW    destination start address
//  cfg_len     in   LENW  number of words
//  cfg_fill    in   DW    FILL data word
//  bus_req     out  1     request for bus ownership
//  bus_gnt     in   1     ownership granted (arbiter may drop it at any cycle)
//  m_we        out  1     write enable to data memory
//  m_addr      out  AW    address to data memory
//  m_wdata     out  DW    write data (drives memory data_in)
//  m_rdata     in   DW    read data (memory data_out, valid 1 cycle after address; RAM is registered)
//  busy        out  1     transfer in progress (REQ..WR states)
//  done        out  1     1-cycle pulse at end of transfer
//  checksum    out  DW    see CONFIGURATION
// BEHAVIOUR
//  Reset: state=IDLE; bus_req, m_we, busy, done=0; m_addr, m_wdata, checksum=0; counters cleared.
//  FSM states: IDLE, REQ, RD, WAIT, WR, FIN.
//   IDLE: start=1 -> latch cfg; if cfg_len=0 -> FIN (no bus_req, no bus cycle), else -> REQ.
//   REQ:  bus_req=1; on gnt go to RD (COPY) or WR (FILL). bus_req stays 1 until FIN.
//   RD:   m_addr=src_ptr, m_we=0 -> WAIT.
//   WAIT: m_addr held; m_rdata captured into data register at the end of the cycle -> WR.
//   WR:   m_addr=dst_ptr, m_wdata=captured word (COPY) or cfg_fill (FILL), m_we=1. Then remaining--,
//         src_ptr++, dst_ptr++. If remaining becomes 0 -> FIN, else -> RD (COPY) or WR (FILL).
//   FIN:  done=1 for one cycle, bus_req=0 -> IDLE.
//  Throughput: COPY 3 cycles/word, FILL 1 cycle/word after grant.
//  m_we is asserted only in WR, and only when bus_gnt=1 in that same cycle (combinational gate).
//  Grant loss: gnt=0 in RD/WAIT/WR -> no write and no pointer/count update; FSM enters REQ, keeps bus_req=1,
//   and resumes at RD (COPY, read re-issued) or WR (FILL). The word is never skipped or duplicated.
//  Pointers: AW-bit, wrap modulo 2^AW (0x7FFF+1 -> 0x0000). No range check; unmapped writes are harmless.
//  start while busy: ignored, no cfg change. start in the same cycle as FIN: ignored (accepted only in IDLE).
//  rst_n low mid-transfer: immediate return to reset values; no partial completion, no done.
// CONFIGURATION
//  DMA_CHECKSUM_EN defined: checksum = DW-bit wrap-around sum of all words written during the last transfer.
//   Cleared on accepted start; final when done pulses; held until the next start.
//  Not defined: checksum tied to '0; no accumulator logic.
// STRUCTURE
//  hack_bus_pkg: AW/DW defaults, dma_mode_e {DMA_COPY, DMA_FILL}, dma_state_e (FSM states above),
//   address-map constants (RAM_START/RAM_END, OREG/IREG bases) shared with data memory and the testbench.
//  Sub-module: dmem_addr_ctr (loadable AW-bit wrapping incrementer with enable), one instance each for
//   src_ptr and dst_ptr.
// TESTING (bench uses the real data memory model with 1-cycle read latency; gnt=1 unless noted)
//  FILL dst=0x0010 len=4 fill=0xBEEF -> 4 writes on consecutive cycles, RAM[0x10..0x13]=0xBEEF, done once.
//  COPY src=0x0100 -> dst=0x0200 len=3, RAM[0x100..102]=1,2,3 -> RAM[0x200..202]=1,2,3; 9 cycles grant-to-FIN.
//  len=0 start -> done 1 cycle after IDLE, bus_req never 1, no m_we.
//  COPY len=4, gnt dropped 2 cycles during the 2nd word's WAIT -> re-read issued, dst contents exact, 4 writes.
//  FILL dst=0x7FFE len=3 val=0x00A5 -> writes at 0x7FFE, 0x7FFF, 0x0000; checksum=0x01EF if DMA_CHECKSUM_EN.
//  rst_n pulsed after 2nd word of COPY len=8 -> outputs at reset values, only 2 words written, no done.

Source files
------------

// File: rtl/hack_bus_pkg.sv
// Shared definitions for the HACK data-memory bus: widths, DMA mode and
// FSM state encodings, and the address map used by data memory and benches.
package hack_bus_pkg;

    localparam int AW   = 15;  // data-memory address width
    localparam int DW   = 16;  // data word width
    localparam int LENW = 15;  // transfer-length counter width

    // Address map of the data-memory space.
    localparam logic [AW-1:0] RAM_START = 15'h0000;
    localparam logic [AW-1:0] RAM_END   = 15'h3FFF;
    localparam logic [AW-1:0] OREG_BASE = 15'h4000;  // memory-mapped output registers
    localparam logic [AW-1:0] IREG_BASE = 15'h6000;  // memory-mapped input registers

    typedef enum logic {
        DMA_COPY = 1'b0,
        DMA_FILL = 1'b1
    } dma_mode_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_WAIT = 3'd3,
        S_WR   = 3'd4,
        S_FIN  = 3'd5
    } dma_state_e;

endpackage

// File: rtl/dmem_addr_ctr.sv
// Loadable AW-bit address pointer. Load has priority over increment; the
// increment wraps modulo 2^AW.
module dmem_addr_ctr #(
    parameter int AW = 15
) (
    input  logic          clk50m,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          en,
    output logic [AW-1:0] q
);

    logic [AW-1:0] cnt_d;
    logic [AW-1:0] cnt_q;

    // Next pointer value: load a new base, or step by one with natural wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q + AW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/dmem_dma_master.sv
// DMA bus initiator for the HACK data-memory bus. Performs COPY (read then
// write, 3 cycles/word) or FILL (1 cycle/word) transfers after winning the
// bus through a req/gnt handshake. Loss of grant aborts the current word
// cleanly and it is retried once grant returns.
// Optional feature: define DMA_CHECKSUM_EN to enable a running wrap-around
// sum of all words written during the last transfer on the checksum port.
module dmem_dma_master #(
    parameter int AW   = hack_bus_pkg::AW,
    parameter int DW   = hack_bus_pkg::DW,
    parameter int LENW = hack_bus_pkg::LENW
) (
    input  logic            clk50m,
    input  logic            rst_n,
    input  logic            start,
    input  logic            cfg_mode,
    input  logic [AW-1:0]   cfg_src,
    input  logic [AW-1:0]   cfg_dst,
    input  logic [LENW-1:0] cfg_len,
    input  logic [DW-1:0]   cfg_fill,
    output logic            bus_req,
    input  logic            bus_gnt,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic [DW-1:0]   m_rdata,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   checksum
);

    import hack_bus_pkg::*;

    dma_state_e      state_d,     state_q;
    dma_mode_e       mode_d,      mode_q;
    logic [LENW-1:0] remaining_d, remaining_q;
    logic [DW-1:0]   fill_d,      fill_q;
    logic [DW-1:0]   data_d,      data_q;

    logic            start_acc;   // start accepted this cycle (only in IDLE)
    logic            wr_fire;     // a write actually reaches memory this cycle
    logic [AW-1:0]   src_ptr;
    logic [AW-1:0]   dst_ptr;

    // Source and destination pointers: loaded on accepted start, advanced
    // together only when a write really happens, so a lost grant never
    // skips or repeats a word.
    dmem_addr_ctr #(.AW(AW)) u_src_ctr (
        .clk50m   (clk50m),
        .rst_n    (rst_n),
        .load     (start_acc),
        .load_val (cfg_src),
        .en       (wr_fire),
        .q        (src_ptr)
    );

    dmem_addr_ctr #(.AW(AW)) u_dst_ctr (
        .clk50m   (clk50m),
        .rst_n    (rst_n),
        .load     (start_acc),
        .load_val (cfg_dst),
        .en       (wr_fire),
        .q        (dst_ptr)
    );

    // FSM next-state logic and bus outputs.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d     = state_q;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        fill_d      = fill_q;
        data_d      = data_q;
        start_acc   = 1'b0;
        wr_fire     = 1'b0;
        bus_req     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        m_we        = 1'b0;
        m_addr      = '0;
        m_wdata     = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_acc   = 1'b1;
                    mode_d      = dma_mode_e'(cfg_mode);
                    remaining_d = cfg_len;
                    fill_d      = cfg_fill;
                    // A zero-length transfer completes without touching the bus.
                    state_d     = (cfg_len == '0) ? S_FIN : S_REQ;
                end
            end

            S_REQ: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                if (bus_gnt) begin
                    state_d = (mode_q == DMA_FILL) ? S_WR : S_RD;
                end
            end

            S_RD: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                m_addr  = src_ptr;
                state_d = bus_gnt ? S_WAIT : S_REQ;
            end

            S_WAIT: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                m_addr  = src_ptr;
                if (bus_gnt) begin
                    // Registered RAM presents the word one cycle after the address.
                    data_d  = m_rdata;
                    state_d = S_WR;
                end else begin
                    state_d = S_REQ;
                end
            end

            S_WR: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                m_addr  = dst_ptr;
                m_wdata = (mode_q == DMA_FILL) ? fill_q : data_q;
                if (bus_gnt) begin
                    m_we        = 1'b1;
                    wr_fire     = 1'b1;
                    remaining_d = remaining_q - LENW'(1);
                    if (remaining_q == LENW'(1)) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = (mode_q == DMA_FILL) ? S_WR : S_RD;
                    end
                end else begin
                    state_d = S_REQ;
                end
            end

            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and transfer context registers.
    always_ff @(posedge clk50m or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= DMA_COPY;
            remaining_q <= '0;
            fill_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
            fill_q      <= fill_d;
            data_q      <= data_d;
        end
    end

`ifdef DMA_CHECKSUM_EN
    logic [DW-1:0] sum_d, sum_q;

    // Running sum of written words, restarted by each accepted start.
    always_comb begin
        sum_d = sum_q;
        if (start_acc) begin
            sum_d = '0;
        end else if (wr_fire) begin
            sum_d = sum_q + m_wdata;
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule
